// File: rtl/wave_dac_spi.sv
// wave_dac_spi: serializes 8-bit wave_dac samples into 16-bit SPI mode-0 frames {CTRL_BITS, sample, 4'b0}.
// Optional WAVE_DAC_SPI_DUP_SKIP_EN: a sample equal to the last transmitted one is accepted but not sent.
module wave_dac_spi #(
  parameter int          CLK_DIV   = 2,
  parameter int          CS_GAP    = 2,
  parameter logic [3:0]  CTRL_BITS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam int CMAX = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt, w_cnt;
  logic [4:0]     r_ph, w_ph;
  logic [15:0]    r_sh, w_sh;
  logic           r_cs_n, r_sclk, r_ready, r_done;
  logic           w_cs_n, w_sclk, w_ready, w_done;
  logic           w_accept, w_skip, w_div_end, w_gap_end;
  assign w_accept  = sample_valid && r_ready;
  assign w_div_end = r_cnt == CW'(CLK_DIV - 1);
  assign w_gap_end = r_cnt == CW'(CS_GAP - 1);
`ifdef WAVE_DAC_SPI_DUP_SKIP_EN
  logic [7:0] r_last;
  logic       r_last_vld;
  assign w_skip = r_last_vld && (sample_in == r_last);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept && !w_skip) r_last <= sample_in;
      if (w_done) r_last_vld <= 1'b1;
    end
  end
`else
  assign w_skip = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ph    <= '0;
      r_sh    <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_ph    <= w_ph;
      r_sh    <= w_sh;
      r_cs_n  <= w_cs_n;
      r_sclk  <= w_sclk;
      r_ready <= w_ready;
      r_done  <= w_done;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_skip) w_next = SETUP;
      SETUP:   if (w_div_end) w_next = SHIFT;
      SHIFT:   if (w_div_end && r_ph == 5'd31) w_next = HOLD;
      HOLD:    if (w_div_end) w_next = GAP;
      GAP:     if (w_gap_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Even SHIFT phases are sclk high; din advances as each high phase ends, except the last bit.
  always_comb begin
    w_cnt   = (r_state == IDLE || w_next != r_state || (r_state == SHIFT && w_div_end)) ? '0 : r_cnt + 1'b1;
    w_ph    = r_state != SHIFT ? 5'd0 : w_div_end ? r_ph + 5'd1 : r_ph;
    w_sh    = (r_state == IDLE && w_accept && !w_skip) ? {CTRL_BITS, sample_in, 4'b0000} :
              (r_state == SHIFT && w_div_end && !r_ph[0] && r_ph != 5'd30) ? {r_sh[14:0], 1'b0} :
              (r_state == HOLD && w_div_end) ? 16'h0000 : r_sh;
    w_sclk  = (w_next == SHIFT) && !w_ph[0];
    w_cs_n  = !(w_next inside {SETUP, SHIFT, HOLD});
    w_ready = w_next == IDLE;
    w_done  = (r_state == HOLD) && (w_next == GAP);
  end
  assign sample_ready = r_ready;
  assign dac_cs_n     = r_cs_n;
  assign dac_sclk     = r_sclk;
  assign dac_din      = r_sh[15];
  assign frame_done   = r_done;
endmodule

// File: tb/tb_wave_dac_spi.sv
// tb_wave_dac_spi: directed checks of wave_dac_spi at defaults plus a CLK_DIV=1/CS_GAP=1/CTRL=1001 instance.
module tb_wave_dac_spi;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] sample_in = '0, b_sample = '0;
  logic sample_valid = 1'b0, b_valid = 1'b0;
  logic sample_ready, dac_cs_n, dac_sclk, dac_din, frame_done;
  logic b_ready, b_cs_n, b_sclk, b_din, b_done;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  wave_dac_spi u_a (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk),
    .dac_din(dac_din), .frame_done(frame_done));

  wave_dac_spi #(.CLK_DIV(1), .CS_GAP(1), .CTRL_BITS(4'b1001)) u_b (
    .clk(clk), .rst_n(rst_n), .sample_in(b_sample), .sample_valid(b_valid),
    .sample_ready(b_ready), .dac_cs_n(b_cs_n), .dac_sclk(b_sclk),
    .dac_din(b_din), .frame_done(b_done));

  // Frame monitor for u_a, sampled on the falling clk edge
  logic p_cs = 1'b1, p_sclk = 1'b0, p_rdy = 1'b0, done_ok = 1'b1;
  int cs_low = 0, cs_high = 0, rdy_low = 0, rises = 0, dones = 0;
  logic [15:0] cap = '0;
  logic [15:0] fr_q[$];
  int low_q[$], rise_q[$], hi_q[$], rdy_q[$];
  initial forever begin
    @(negedge clk);
    if (p_cs && !dac_cs_n) begin hi_q.push_back(cs_high); cs_high = 0; cs_low = 0; rises = 0; cap = '0; end
    if (dac_cs_n) cs_high++; else cs_low++;
    if (!p_sclk && dac_sclk) begin cap = {cap[14:0], dac_din}; rises++; end
    if (!p_cs && dac_cs_n && rst_n) begin fr_q.push_back(cap); low_q.push_back(cs_low); rise_q.push_back(rises); end
    if (frame_done) begin dones++; if (p_cs || !dac_cs_n) done_ok = 1'b0; end
    if (!sample_ready) rdy_low++;
    if (!p_rdy && sample_ready) begin rdy_q.push_back(rdy_low); rdy_low = 0; end
    p_cs = dac_cs_n; p_sclk = dac_sclk; p_rdy = sample_ready;
  end

  // Frame monitor for u_b
  logic b_pcs = 1'b1, b_psclk = 1'b0;
  logic [15:0] b_cap = '0;
  int b_low = 0, b_hi = 0, b_rises = 0, b_frames = 0;
  initial forever begin
    @(negedge clk);
    if (b_pcs && !b_cs_n) begin b_cap = '0; b_rises = 0; b_low = 0; b_hi = 0; end
    if (!b_cs_n) begin b_low++; if (b_sclk) b_hi++; end
    if (!b_psclk && b_sclk) begin b_cap = {b_cap[14:0], b_din}; b_rises++; end
    if (!b_pcs && b_cs_n && rst_n) b_frames++;
    b_pcs = b_cs_n; b_psclk = b_sclk;
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] s);
    sample_in = s; sample_valid = 1'b1; step(); sample_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!sample_ready && k < 300) begin step(); k++; end
    chk("ready_timeout", 32'(k < 300), 1);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (fr_q.size() < n && k < 400) begin step(); k++; end
    chk("frame_timeout", fr_q.size(), n);
  endtask

  int n0, r0, h0, d0, k;
  logic idle_bad;
  initial begin
    step(); step();
    chk("rst_cs_n", dac_cs_n, 1);
    chk("rst_sclk", dac_sclk, 0);
    chk("rst_din", dac_din, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", sample_ready, 0);
    rst_n = 1'b1; step(); step();
    chk("idle_ready", sample_ready, 1);
    idle_bad = 1'b0;
    repeat (500) begin
      step();
      if (!dac_cs_n || dac_sclk || !sample_ready || frame_done) idle_bad = 1'b1;
    end
    chk("idle_hold", idle_bad, 0);
    chk("idle_no_done", dones, 0);
    // single frame
    send(8'hA5);
    chk("ready_drop", sample_ready, 0);
    chk("cs_fall", dac_cs_n, 0);
    wait_frames(1);
    chk("single_frame", fr_q[0], 16'h0A50);
    chk("single_cs_low", low_q[0], 68);
    chk("single_rises", rise_q[0], 16);
    chk("single_dones", dones, 1);
    chk("done_at_cs_rise", done_ok, 1);
    repeat (5) step();
    chk("single_rdy_low", rdy_q[$], 70);
    // back-to-back with valid held high
    n0 = fr_q.size(); r0 = rdy_q.size(); h0 = hi_q.size();
    sample_in = 8'h00; sample_valid = 1'b1; step();
    sample_in = 8'hFF; wait_ready(); step();
    sample_in = 8'h80; wait_ready(); step();
    sample_valid = 1'b0;
    wait_frames(n0 + 3);
    repeat (5) step();
    chk("b2b_f0", fr_q[n0], 16'h0000);
    chk("b2b_f1", fr_q[n0+1], 16'h0FF0);
    chk("b2b_f2", fr_q[n0+2], 16'h0800);
    chk("b2b_gap1", hi_q[h0+1], 3);
    chk("b2b_gap2", hi_q[h0+2], 3);
    chk("b2b_rdy0", rdy_q[r0], 70);
    chk("b2b_rdy1", rdy_q[r0+1], 70);
    chk("b2b_rdy2", rdy_q[r0+2], 70);
    chk("done_at_cs_rise2", done_ok, 1);
    // repeated sample
    n0 = fr_q.size();
    send(8'h40); repeat (80) step();
    send(8'h40);
`ifdef WAVE_DAC_SPI_DUP_SKIP_EN
    chk("dup_ready", sample_ready, 1);
`else
    chk("dup_ready", sample_ready, 0);
`endif
    repeat (80) step();
    send(8'h41); repeat (80) step();
`ifdef WAVE_DAC_SPI_DUP_SKIP_EN
    chk("dup_frames", fr_q.size() - n0, 2);
`else
    chk("dup_frames", fr_q.size() - n0, 3);
`endif
    chk("dup_first", fr_q[n0], 16'h0400);
    chk("dup_last", fr_q[$], 16'h0410);
    // reset mid-frame
    d0 = dones;
    send(8'h55); step();
    k = 0;
    while (rises < 5 && k < 200) begin step(); k++; end
    chk("rise5_reached", rises, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", dac_cs_n, 1);
    chk("abort_sclk", dac_sclk, 0);
    chk("abort_din", dac_din, 0);
    chk("abort_ready", sample_ready, 0);
    step(); step();
    chk("abort_no_done", dones, d0);
    rst_n = 1'b1; step(); step();
    n0 = fr_q.size();
    send(8'h12);
    wait_frames(n0 + 1);
    chk("post_rst_frame", fr_q[$], 16'h0120);
    chk("post_rst_dones", dones, d0 + 1);
    // fast instance
    b_sample = 8'h3C; b_valid = 1'b1; step(); b_valid = 1'b0;
    k = 0;
    while (b_frames < 1 && k < 200) begin step(); k++; end
    chk("fast_frames", b_frames, 1);
    chk("fast_frame", b_cap, 16'h93C0);
    chk("fast_cs_low", b_low, 34);
    chk("fast_rises", b_rises, 16);
    chk("fast_high_cycles", b_hi, 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
